// File: rtl/fp16_mult_writeback.sv
// fp16_mult_writeback: writeback stage behind the combinational fp16 multiplier.
// Captures operand pairs and their product into a small FIFO, classifies the
// product, and accumulates sticky IEEE exception flags {NV, OF, UF}.
module fp16_mult_writeback #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      float1,
  input  logic [15:0]      float2,
  input  logic [15:0]      product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_result,
  output logic [2:0]       out_class,
  output logic [2:0]       flags,
  input  logic             flags_clear,
  output logic [CNT_W-1:0] count,
  output logic [15:0]      ops_accepted
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_SUB  = 3'd1,
    CLS_NORM = 3'd2,
    CLS_INF  = 3'd3,
    CLS_QNAN = 3'd4,
    CLS_SNAN = 3'd5
  } fp_class_e;

  // Field tests are written as masks on the whole word; the sign never matters.
  function automatic logic exp_zero(input logic [15:0] x);
    return (x & 16'h7C00) == 16'h0000;
  endfunction

  function automatic logic exp_ones(input logic [15:0] x);
    return (x & 16'h7C00) == 16'h7C00;
  endfunction

  function automatic logic mant_zero(input logic [15:0] x);
    return (x & 16'h03FF) == 16'h0000;
  endfunction

  function automatic logic quiet_bit(input logic [15:0] x);
    return (x & 16'h0200) != 16'h0000;
  endfunction

  function automatic fp_class_e classify(input logic [15:0] x);
    if (exp_zero(x))       return mant_zero(x) ? CLS_ZERO : CLS_SUB;
    else if (!exp_ones(x)) return CLS_NORM;
    else if (mant_zero(x)) return CLS_INF;
    else if (quiet_bit(x)) return CLS_QNAN;
    else                   return CLS_SNAN;
  endfunction

  logic [15:0]      res_mem [DEPTH];
  logic [2:0]       cls_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic      push;
  logic      pop;
  fp_class_e push_class;
  logic [2:0] flag_set;

  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  logic a_special, b_special;

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head is read straight from storage; empty reads are forced to zero so
  // stale, never-reset entries cannot leak out.
  assign out_result = out_valid ? res_mem[rd_ptr] : 16'h0000;
  assign out_class  = out_valid ? cls_mem[rd_ptr] : 3'd0;

  // Operand predicates and the exception flags this push would raise.
  always_comb begin
    // NOTE: every signal assigned here gets a value before any condition, so no latch is inferred.
    a_zero     = exp_zero(float1) & mant_zero(float1);
    b_zero     = exp_zero(float2) & mant_zero(float2);
    a_inf      = exp_ones(float1) & mant_zero(float1);
    b_inf      = exp_ones(float2) & mant_zero(float2);
    a_nan      = exp_ones(float1) & ~mant_zero(float1);
    b_nan      = exp_ones(float2) & ~mant_zero(float2);
    a_snan     = a_nan & ~quiet_bit(float1);
    b_snan     = b_nan & ~quiet_bit(float2);
    a_special  = a_inf | a_nan;
    b_special  = b_inf | b_nan;
    push_class = classify(product);
    flag_set   = 3'b000;
    // NV: signaling NaN input, or zero times infinity.
    flag_set[2] = a_snan | b_snan | (a_zero & b_inf) | (a_inf & b_zero);
    // OF: infinite result from finite operands.
    flag_set[1] = (push_class == CLS_INF) & ~a_special & ~b_special;
    // UF: zero/subnormal result from nonzero finite operands.
    flag_set[0] = ((push_class == CLS_ZERO) | (push_class == CLS_SUB))
                  & ~a_zero & ~b_zero & ~a_special & ~b_special;
  end

  // Entry storage written at the write pointer on every push.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; only the pointers and count define which entries are live.
    if (push && !rst) begin
      res_mem[wr_ptr] <= product;
      cls_mem[wr_ptr] <= push_class;
    end
  end

  // Pointers, occupancy, sticky flags and the accepted-op counter.
  always_ff @(posedge clk) begin
    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      flags        <= 3'b000;
      ops_accepted <= 16'h0000;
    end else begin
      if (push) begin
        wr_ptr       <= wr_ptr + PTR_W'(1);
        ops_accepted <= ops_accepted + 16'h0001;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      // A clear only wipes history; the current push's flags still land.
      flags <= (flags_clear ? 3'b000 : flags) | (push ? flag_set : 3'b000);
    end
  end

endmodule

// File: tb/tb_fp16_mult_writeback.sv
// Directed self-checking bench for fp16_mult_writeback (DEPTH = 4).
module tb_fp16_mult_writeback;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      float1;
  logic [15:0]      float2;
  logic [15:0]      product;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_result;
  logic [2:0]       out_class;
  logic [2:0]       flags;
  logic             flags_clear;
  logic [CNT_W-1:0] count;
  logic [15:0]      ops_accepted;

  int compared   = 0;
  int mismatched = 0;

  fp16_mult_writeback #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .float1       (float1),
    .float2       (float2),
    .product      (product),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_class    (out_class),
    .flags        (flags),
    .flags_clear  (flags_clear),
    .count        (count),
    .ops_accepted (ops_accepted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic [15:0] p);
    in_valid = v;
    float1   = a;
    float2   = b;
    product  = p;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; float1 = '0; float2 = '0; product = '0;
    out_ready = 1'b0; flags_clear = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", 32'(out_result), 32'h0);
    check("rst_out_class", 32'(out_class), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ops", 32'(ops_accepted), 32'd0);

    // Single push: 1.0 * 2.0 = 2.0
    drive(1'b1, 16'h3C00, 16'h4000, 16'h4000);
    tick();
    drive(1'b0, '0, '0, '0);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_result", 32'(out_result), 32'h4000);
    check("single_class", 32'(out_class), 32'd2);
    check("single_flags", 32'(flags), 32'd0);
    check("single_count", 32'(count), 32'd1);
    check("single_ops", 32'(ops_accepted), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single_pop_valid", 32'(out_valid), 32'd0);
    check("single_pop_result", 32'(out_result), 32'h0);

    // Fill to DEPTH with the consumer stalled
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 16'h3C00, 16'h3C00, 16'h1000 + 16'(i));
      tick();
    end
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_count", 32'(count), 32'(DEPTH));
    check("full_ops", 32'(ops_accepted), 32'd5);
    drive(1'b1, 16'h3C00, 16'h3C00, 16'hDEAD);
    tick();
    drive(1'b0, '0, '0, '0);
    check("overfill_ops", 32'(ops_accepted), 32'd5);
    check("overfill_count", 32'(count), 32'(DEPTH));
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain_%0d", i), 32'(out_result), 32'(16'h1000 + 16'(i)));
      tick();
    end
    out_ready = 1'b0;
    check("drain_empty", 32'(out_valid), 32'd0);
    check("drain_in_ready", 32'(in_ready), 32'd1);

    // Refill after pointer wrap
    drive(1'b1, 16'h3C00, 16'h3C00, 16'h2000); tick();
    drive(1'b1, 16'h3C00, 16'h3C00, 16'h2001); tick();
    drive(1'b0, '0, '0, '0);
    check("wrap_count", 32'(count), 32'd2);
    out_ready = 1'b1;
    check("wrap_head0", 32'(out_result), 32'h2000);
    tick();
    check("wrap_head1", 32'(out_result), 32'h2001);
    tick();
    check("wrap_empty", 32'(count), 32'd0);

    // Exception classes; consumer stays ready so each new push becomes the head
    drive(1'b1, 16'h0000, 16'h7C00, 16'hFFFF); tick();
    drive(1'b0, '0, '0, '0);
    check("zero_x_inf_class", 32'(out_class), 32'd4);
    check("zero_x_inf_flags", 32'(flags), 32'b100);
    flags_clear = 1'b1; tick(); flags_clear = 1'b0;
    check("clear_flags", 32'(flags), 32'b000);

    drive(1'b1, 16'h7C01, 16'h3C00, 16'h7E01); tick();
    drive(1'b0, '0, '0, '0);
    check("snan_flags", 32'(flags), 32'b100);
    flags_clear = 1'b1; tick(); flags_clear = 1'b0;

    drive(1'b1, 16'h7BFF, 16'h7BFF, 16'h7C00); tick();
    drive(1'b0, '0, '0, '0);
    check("of_class", 32'(out_class), 32'd3);
    check("of_flags", 32'(flags), 32'b010);
    flags_clear = 1'b1; tick(); flags_clear = 1'b0;

    drive(1'b1, 16'h0001, 16'h0001, 16'h0000); tick();
    drive(1'b0, '0, '0, '0);
    check("uf_class", 32'(out_class), 32'd0);
    check("uf_flags", 32'(flags), 32'b001);
    flags_clear = 1'b1; tick(); flags_clear = 1'b0;

    drive(1'b1, 16'h7C00, 16'h3C00, 16'h7C00); tick();
    drive(1'b0, '0, '0, '0);
    check("inf_x_one_class", 32'(out_class), 32'd3);
    check("inf_x_one_flags", 32'(flags), 32'b000);
    tick();

    // Clear collides with a push that raises only UF
    drive(1'b1, 16'h0000, 16'h7C00, 16'hFFFF); tick();
    drive(1'b1, 16'h7BFF, 16'h7BFF, 16'h7C00); tick();
    drive(1'b1, 16'h0001, 16'h0001, 16'h0000); tick();
    check("all_flags", 32'(flags), 32'b111);
    drive(1'b1, 16'h0001, 16'h0001, 16'h0000);
    flags_clear = 1'b1;
    tick();
    flags_clear = 1'b0;
    drive(1'b0, '0, '0, '0);
    check("clear_collide_flags", 32'(flags), 32'b001);
    tick();
    check("collide_drained", 32'(count), 32'd0);

    // Simultaneous push/pop at count == 1
    flags_clear = 1'b1; tick(); flags_clear = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 16'h3C00, 16'h3C00, 16'h3000); tick();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'h0000, 16'h7C00, 16'h3000 + 16'(i));
      tick();
      check($sformatf("stream_count_%0d", i), 32'(count), 32'd1);
      check($sformatf("stream_head_%0d", i), 32'(out_result), 32'(16'h3000 + 16'(i)));
    end
    check("stream_flags", 32'(flags), 32'b100);

    // Reset mid-stream, in_valid still high
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, '0, '0, '0);
    out_ready = 1'b0;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_flags", 32'(flags), 32'd0);
    check("midrst_ops", 32'(ops_accepted), 32'd0);
    check("midrst_result", 32'(out_result), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fp16_mult_writeback.md
# fp16_mult_writeback

Result writeback stage placed directly downstream of the combinational half-precision multiplier. It captures each operand pair and its product under a valid/ready handshake and buffers them in a small FIFO. On capture it classifies the product and updates sticky IEEE exception flags (invalid, overflow, underflow). It then presents results in order to the register-file/writeback consumer.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, 2 to 16.
- CNT_W, $clog2(DEPTH)+1: occupancy counter width.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk, input, 1: sole clock; all state updates on rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: float1/float2/product valid this cycle.
- in_ready, output, 1: entry can be accepted; equals (count != DEPTH), registered-state only.
- float1, input, 16: multiplier operand A (fp16).
- float2, input, 16: multiplier operand B (fp16).
- product, input, 16: multiplier output for float1*float2.
- out_valid, output, 1: head entry present (count != 0).
- out_ready, input, 1: consumer accepts head entry.
- out_result, output, 16: head product; 16'h0000 when empty.
- out_class, output, 3: head classification; 3'd0 when empty.
- flags, output, 3: sticky {NV, OF, UF}.
- flags_clear, input, 1: clears sticky flags.
- count, output, CNT_W: current occupancy.
- ops_accepted, output, 16: total accepted entries; wraps at 16'hFFFF→0.

## Operation
- Push: in_valid & in_ready. Pop: out_valid & out_ready. Push and pop in the same cycle are allowed, including when count==1. When full, in_ready=0, so a pop never coincides with a push.
- FIFO: write pointer and read pointer, log2(DEPTH) bits each; both wrap modulo DEPTH. count += push - pop.
- out_class for the product (e = bits[14:10], m = bits[9:0]):
  - 0 = zero (e=0, m=0)
  - 1 = subnormal (e=0, m≠0)
  - 2 = normal
  - 3 = inf (e=31, m=0)
  - 4 = qNaN (e=31, m[9]=1)
  - 5 = sNaN (e=31, m≠0, m[9]=0)
- Classification is computed at push and stored with the entry.
- Operand predicates are evaluated on float1/float2 at push:
  - zero: exp=0 and mant=0, either sign.
  - inf: exp=31 and mant=0.
  - nan: exp=31 and mant≠0.
  - snan: nan and mant[9]=0.
- NV sets on push when either operand is snan, or when one operand is zero and the other is inf.
- OF sets on push when product class=3 and neither operand is inf or nan.
- UF sets on push when product class is 0 or 1, neither operand is zero, and neither operand is inf or nan.
- Flags are sticky until flags_clear or rst. If flags_clear and a setting push occur in the same cycle, the new push's flags are set (set wins). Flags from earlier pushes are cleared.
- ops_accepted increments by 1 on every push.

## Timing
- Reset values: in_ready=1, out_valid=0, out_result=0, out_class=0, flags=0, count=0, ops_accepted=0, pointers=0. FIFO storage is not reset.
- rst mid-operation drops all buffered entries on the next edge. in_valid is ignored during the rst cycle.
- Latency: a push in cycle N appears at the head (if the FIFO was empty) with out_valid=1 in cycle N+1. Flags reflect it in cycle N+1.
- out_* are driven from registered storage and the read pointer. There is no combinational path from in_* to out_*, and none from out_ready to in_ready.
- Throughput: one push and one pop per cycle sustained.
- Once out_valid is asserted, out_result and out_class hold stable until popped.

## Test plan
- Reset then single push: float1=16'h3C00, float2=16'h4000, product=16'h4000. Required in the next cycle: out_valid=1, out_result=16'h4000, out_class=2, flags=0, count=1, ops_accepted=1. Then pop with out_ready=1 → out_valid=0, out_result=0.
- Fill: DEPTH pushes with out_ready=0 → in_ready=0 and count=DEPTH. Then one more in_valid → no push, ops_accepted unchanged. Pop all four → products emerge in push order; pointers wrap correctly on the next fill.
- Invalid: float1=16'h0000, float2=16'h7C00, product=16'hFFFF → out_class=4, flags=3'b100. Separately, float1=16'h7C01 → NV set.
- Overflow and underflow:
  - 16'h7BFF×16'h7BFF with product 16'h7C00 → OF set, class 3.
  - 16'h0001×16'h0001 with product 16'h0000 → UF set, class 0.
  - 16'h7C00×16'h3C00 with product 16'h7C00 → OF remains 0.
- Clear collision: flags=3'b111; flags_clear asserted in the same cycle as a push that sets only UF → flags=3'b001 next cycle.
- Simultaneous push/pop at count=1 for 8 cycles → count stays 1 and outputs follow push order. Assert rst mid-stream → count=0, out_valid=0, flags=0 next cycle.
